// File: rtl/mainfsm_hs_if.sv
// Handshake/control bundle between the decoder/memory/FPU side and the
// multicycle main control FSM. The master modport is the FSM itself; the
// slave modport is the datapath/environment that consumes the strobes.
interface mainfsm_hs_if #(
  parameter int WB_BEATS = 2
);

  localparam int BW = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1;

  // Decoder and handshake inputs to the FSM
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic          Long;
  logic          MemReady;
  logic          FpuDone;

  // Datapath strobes and selects driven by the FSM
  logic          IRWrite;
  logic          NextPC;
  logic          RegW;
  logic          MemW;
  logic          Branch;
  logic          ALUOp;
  logic          AdrSrc;
  logic [1:0]    ResultSrc;
  logic [1:0]    ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic          FpuStart;
  logic [BW-1:0] WbIdx;
  logic          Fault;
  logic [3:0]    State;

  modport master (
    input  Op, Funct, Long, MemReady, FpuDone,
    output IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, FpuStart, WbIdx, Fault, State
  );

  modport slave (
    output Op, Funct, Long, MemReady, FpuDone,
    input  IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, FpuStart, WbIdx, Fault, State
  );

endinterface

// File: rtl/mainfsm_hs.sv
// Multicycle main control FSM for the ARM-subset datapath with memory
// wait states, a start/done handshake to a variable-latency FPU (with a
// timeout fault) and multi-beat register writeback for long multiply.
module mainfsm_hs #(
  parameter int WB_BEATS    = 2,
  parameter bit FPU_EN      = 1'b1,
  parameter int FPU_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mainfsm_hs_if.master  bus
);

  localparam int BW = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1;
  localparam int TW = $clog2(FPU_TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(WB_BEATS - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(FPU_TIMEOUT - 1);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] EXECUTEF = 4'd10;
  localparam logic [3:0] FWAIT    = 4'd11;
  localparam logic [3:0] FWB      = 4'd12;
  localparam logic [3:0] ALUWBX   = 4'd13;
  localparam logic [3:0] FAULT    = 4'd14;

  logic [3:0]    state;
  logic [3:0]    next_state;
  logic [3:0]    dec_state;
  logic [BW-1:0] beat;
  logic [TW-1:0] wait_cnt;
  logic          long_q;
  logic          fault_q;

  logic          ir_write;
  logic          next_pc;
  logic          reg_w;
  logic          mem_w;
  logic          branch;
  logic          alu_op;
  logic          adr_src;
  logic [1:0]    result_src;
  logic [1:0]    alu_src_a;
  logic [1:0]    alu_src_b;
  logic          fpu_start;
  logic [BW-1:0] wb_idx;

  // Only the immediate and load bits of Funct steer this FSM
  logic unused_funct;
  assign unused_funct = ^bus.Funct[4:1];

  // Next-state selection; wait states hold until the handshake completes
  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (bus.MemReady) next_state = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   next_state = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = (FPU_EN != 1'b0) ? EXECUTEF : FAULT;
        endcase
      end
      MEMADR:   next_state = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (bus.MemReady) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWR:    if (bus.MemReady) next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = (long_q && (WB_BEATS > 1)) ? ALUWBX : FETCH;
      ALUWBX:   if (beat == LAST_BEAT) next_state = FETCH;
      BRANCH:   next_state = FETCH;
      EXECUTEF: next_state = FWAIT;
      FWAIT: begin
        if (bus.FpuDone)
          next_state = FWB;
        else if (wait_cnt == LAST_WAIT)
          next_state = FAULT;
      end
      FWB:      next_state = FETCH;
      FAULT:    next_state = FAULT;
      default:  next_state = FETCH;
    endcase
  end

  // State register; reset aborts any operation back to FETCH
  always_ff @(posedge clk) begin
    if (reset)
      state <= FETCH;
    else
      state <= next_state;
  end

  // Long request is captured only while executing so later changes are ignored
  always_ff @(posedge clk) begin
    if (reset)
      long_q <= 1'b0;
    else if (state == EXECUTER || state == EXECUTEI)
      long_q <= bus.Long;
  end

  // Writeback beat index: ALUWB is beat 0, ALUWBX walks beats 1..WB_BEATS-1
  always_ff @(posedge clk) begin
    if (reset)
      beat <= '0;
    else if (state == ALUWB)
      beat <= BW'(1);
    else if (state == ALUWBX)
      beat <= beat + BW'(1);
    else
      beat <= '0;
  end

  // FWAIT cycle counter, cleared when the FPU is launched
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (state == EXECUTEF)
      wait_cnt <= '0;
    else if (state == FWAIT)
      wait_cnt <= wait_cnt + TW'(1);
  end

  // Sticky fault flag, raised together with entry into FAULT
  always_ff @(posedge clk) begin
    if (reset)
      fault_q <= 1'b0;
    else if (next_state == FAULT)
      fault_q <= 1'b1;
  end

  // Moore output decode; during reset the selects show FETCH and strobes stay low
  always_comb begin
    dec_state  = reset ? FETCH : state;
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    fpu_start  = 1'b0;
    wb_idx     = '0;
    case (dec_state)
      FETCH: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady & ~reset;
        next_pc    = bus.MemReady & ~reset;
      end
      DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: alu_src_b = 2'b01;
      MEMRD:  adr_src = 1'b1;
      MEMWB: begin
        reg_w      = 1'b1;
        result_src = 2'b01;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        alu_op    = 1'b1;
        alu_src_b = 2'b01;
      end
      ALUWB: reg_w = 1'b1;
      ALUWBX: begin
        reg_w  = 1'b1;
        wb_idx = beat;
      end
      BRANCH: begin
        branch     = 1'b1;
        result_src = 2'b10;
        alu_src_b  = 2'b01;
      end
      EXECUTEF: fpu_start = 1'b1;
      FWB: begin
        reg_w      = 1'b1;
        result_src = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.IRWrite   = ir_write;
  assign bus.NextPC    = next_pc;
  assign bus.RegW      = reg_w;
  assign bus.MemW      = mem_w;
  assign bus.Branch    = branch;
  assign bus.ALUOp     = alu_op;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.FpuStart  = fpu_start;
  assign bus.WbIdx     = wb_idx;
  assign bus.Fault     = fault_q;
  assign bus.State     = state;

endmodule

// File: doc/mainfsm_hs.md
# mainfsm_hs

Parametrised multicycle main control FSM for the ARM-subset datapath. It adds memory wait-state handshaking, a start/done handshake to a variable-latency FPU with timeout fault, and an N-beat register writeback for long multiply. It sits between the instruction decoder (Op/Funct/Long) and the multicycle datapath, driving the same control strobes plus the new handshake, beat-index and fault outputs.

## Interface
- WB_BEATS, 2: writeback beats for long ops (≥1; 1 = Long ignored)
- FPU_EN, 1: 1 = Op=11 dispatched to FPU; 0 = Op=11 enters FAULT
- FPU_TIMEOUT, 16: max FWAIT cycles awaiting FpuDone (≥1)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- Op  in  2  instruction op class
- Funct  in  6  Funct[5] = immediate, Funct[0] = load
- Long  in  1  long-multiply request, sampled in EXECUTER/EXECUTEI
- MemReady  in  1  memory access completes this cycle
- FpuDone  in  1  FPU result valid, sampled in FWAIT only
- IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc  out  1 each  datapath strobes/selects
- ResultSrc, ALUSrcA, ALUSrcB  out  2 each  datapath muxes (ResultSrc=11 selects FPU result)
- FpuStart  out  1  one-cycle FPU launch pulse
- WbIdx  out  max(1,$clog2(WB_BEATS))  writeback beat index (0 = low word)
- Fault  out  1  sticky fault, cleared only by reset
- State  out  4  current state encoding (debug)

## Operation
- Encodings: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXECUTER6 EXECUTEI7 ALUWB8 BRANCH9 EXECUTEF10 FWAIT11 FWB12 ALUWBX13 FAULT14; 15 → FETCH next cycle.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=MemReady; stay until MemReady, then DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Op=00 → EXECUTEI if Funct[5] else EXECUTER; 01 → MEMADR; 10 → BRANCH; 11 → EXECUTEF if FPU_EN else FAULT.
- MEMADR: ALUSrcB=01 → MEMRD if Funct[0] else MEMWR.
- MEMRD: AdrSrc=1; → MEMWB on MemReady, else stay. MEMWB: RegW=1, ResultSrc=01 → FETCH.
- MEMWR: AdrSrc=1, MemW=1 held every cycle until MemReady; → FETCH on MemReady.
- EXECUTER: ALUOp=1. EXECUTEI: ALUOp=1, ALUSrcB=01. Both → ALUWB.
- ALUWB: RegW=1, WbIdx=0. Next ALUWBX if latched Long && WB_BEATS>1, else FETCH.
- ALUWBX: RegW=1, WbIdx=beat (1..WB_BEATS-1, increments per cycle); → FETCH after beat WB_BEATS-1.
- BRANCH: Branch=1, ResultSrc=10, ALUSrcB=01 → FETCH.
- EXECUTEF: FpuStart=1, ALUOp=0, timeout counter cleared → FWAIT.
- FWAIT: counter increments per cycle; FpuDone → FWB; no FpuDone on cycle FPU_TIMEOUT → FAULT.
- FWB: RegW=1, ResultSrc=11 → FETCH.
- FAULT: all strobes 0, Fault=1, stays until reset.
- Any strobe/select not listed for a state is 0.

## Timing
- Reset: next edge state=FETCH, counters/beat/Long latch=0, Fault=0. While reset high, IRWrite, NextPC, RegW, MemW, Branch, FpuStart forced 0 combinationally; selects show FETCH values.
- Reset mid-operation (any state, incl. FWAIT/ALUWBX/FAULT) aborts to FETCH, no further strobes.
- Outputs are Moore decode of State, except IRWrite/NextPC in FETCH (gated by MemReady, same cycle).
- Minimum latencies (MemReady=1): ALU 4 cycles, long ALU 3+WB_BEATS, load 5, store 4, branch 3, FPU 5 + done latency.
- FpuDone in the EXECUTEF cycle is ignored; FpuDone on the final permitted FWAIT cycle wins over timeout.
- FpuStart is exactly one cycle per FPU instruction.
- Long is latched in EXECUTER/EXECUTEI; changes afterward have no effect.

## Test plan
- ADD reg, MemReady=1: states 0,1,6,8,0; RegW high one cycle in ALUWB, ALUOp high in EXECUTER only.
- LDR with MemReady low 3 cycles in MEMRD: MEMRD held 4 cycles, MEMWB RegW=1 ResultSrc=01; FETCH with MemReady low 2 cycles gives no IRWrite until 3rd.
- UMULL-like, Long=1, WB_BEATS=4: ALUWB (WbIdx 0) then ALUWBX WbIdx 1,2,3, four RegW cycles total, then FETCH.
- FPU op, FpuDone after 3 FWAIT cycles: one FpuStart pulse, FWB with ResultSrc=11 RegW=1; FpuDone never with FPU_TIMEOUT=16 → FAULT after 16 FWAIT cycles, Fault=1 held.
- FPU_EN=0, Op=11 → FAULT from DECODE; reset asserted in FAULT → FETCH next edge, Fault=0, no strobes during reset.
